dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory load/store port. It sits behind the core's data port once the datapath moves off the zero-latency Ram.
- Accepts one request at a time over a valid/ready handshake.
- Applies configurable access latency.
- Performs byte/half/word accesses on an internal word array, with RV32I sign/zero extension.
- Returns a response over a second valid/ready handshake.

---
 rtl/dmem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait cycles, RV32I byte/half/word access.
// Define DMEM_FAULT_LATCH_EN to add the sticky first-fault capture outputs fault_valid/fault_addr.
module dmem_responder #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
`ifdef DMEM_FAULT_LATCH_EN
    output logic        fault_valid,
    output logic [31:0] fault_addr,
`endif
    output logic        resp_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    logic        op_write_q;
    logic [31:0] op_addr_q;
    logic [31:0] op_wdata_q;
    logic [2:0]  op_funct3_q;

    logic        cm_write;
    logic [31:0] cm_addr;
    logic [31:0] cm_wdata;
    logic [2:0]  cm_funct3;
    logic        cm_fault;
    logic        accept;
    logic        commit;
    logic [3:0]  cm_strb;
    logic [31:0] cm_lanes;
    logic [31:0] rd_word;

    function automatic logic access_fault(input logic wr, input logic [31:0] addr,
                                          input logic [2:0] f3);
        logic f;
        f = 1'b0;
        case (f3)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = addr[0];
            3'b010:         f = |addr[1:0];
            default:        f = 1'b1;
        endcase
        if (wr && f3[2])
            f = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(MEM_DEPTH))
            f = 1'b1;
        return f;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << lane;
            3'b001:  s = lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Replicate the low bytes across every lane so the strobe alone picks the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b010:  ext = sh;
            3'b100:  ext = {24'd0, sh[7:0]};
            3'b101:  ext = {16'd0, sh[15:0]};
            default: ext = '0;
        endcase
        return ext;
    endfunction

    // With zero latency the access commits on the accepting edge, so it must use the live request.
    always_comb begin
        cm_write  = op_write_q;
        cm_addr   = op_addr_q;
        cm_wdata  = op_wdata_q;
        cm_funct3 = op_funct3_q;
        if (state_q == IDLE) begin
            cm_write  = req_write;
            cm_addr   = req_addr;
            cm_wdata  = req_wdata;
            cm_funct3 = req_funct3;
        end
    end

    assign accept   = (state_q == IDLE) && req_valid;
    assign commit   = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
    assign cm_fault = access_fault(cm_write, cm_addr, cm_funct3);
    assign cm_strb  = store_strobe(cm_funct3, cm_addr[1:0]);
    assign cm_lanes = store_lanes(cm_funct3, cm_wdata);
    assign rd_word  = mem[cm_addr[IDX_W+1:2]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_q  <= req_write;
            op_addr_q   <= req_addr;
            op_wdata_q  <= req_wdata;
            op_funct3_q <= req_funct3;
        end
    end

    // Commit stage: array write and response capture share the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst && commit && cm_write && !cm_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (cm_strb[i])
                    mem[cm_addr[IDX_W+1:2]][8*i +: 8] <= cm_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= cm_fault;
            resp_rdata <= (cm_fault || cm_write) ? 32'd0
                                                 : load_extend(rd_word, cm_addr[1:0], cm_funct3);
        end
    end

`ifdef DMEM_FAULT_LATCH_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_valid <= 1'b0;
            fault_addr  <= 32'd0;
        end else if (commit && cm_fault && !fault_valid) begin
            fault_valid <= 1'b1;
            fault_addr  <= cm_addr;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=1 and a LATENCY=0 instance checked against a byte-level memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err [2];
`ifdef DMEM_FAULT_LATCH_EN
    logic        fault_valid [2];
    logic [31:0] fault_addr [2];
`endif

    dmem_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
`ifdef DMEM_FAULT_LATCH_EN
        .fault_valid(fault_valid[0]), .fault_addr(fault_addr[0]),
`endif
        .resp_err(resp_err[0])
    );

    dmem_responder #(.LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
`ifdef DMEM_FAULT_LATCH_EN
        .fault_valid(fault_valid[1]), .fault_addr(fault_addr[1]),
`endif
        .resp_err(resp_err[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [2][1024];
    bit          fv [2];
    logic [31:0] fa [2];

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size from funct3, alignment by modulo, bytes kept in a flat array.
    task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output bit err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && f3[2]) ||
              ((a % n) != 0) || ((a / 4) >= 256);
        rd = 32'd0;
        if (err) begin
            if (!fv[s]) begin
                fv[s] = 1'b1;
                fa[s] = a;
            end
        end else if (w) begin
            for (int i = 0; i < n; i++)
                mb[s][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v = v | (32'(mb[s][int'(a) + i]) << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1])
                v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic do_req(input int s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] rd_obs, output logic err_obs);
        bit          e_err;
        logic [31:0] e_rd;
        int          cyc;
        @(negedge clk);
        req_write[s]  = w;
        req_addr[s]   = a;
        req_wdata[s]  = wd;
        req_funct3[s] = f3;
        req_valid[s]  = 1'b1;
        cyc = 0;
        while (!req_ready[s] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        model(s, w, a, wd, f3, e_err, e_rd);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!resp_valid[s] && cyc < 40);
        check("resp_latency", 32'(cyc), 32'(lat_of(s) + 1));
        check("resp_rdata", resp_rdata[s], e_rd);
        check("resp_err", 32'(resp_err[s]), 32'(e_err));
        rd_obs  = resp_rdata[s];
        err_obs = resp_err[s];
        for (int k = 0; k < hold; k++) begin
            req_write[s]  = 1'b1;
            req_addr[s]   = 32'h10;
            req_wdata[s]  = $urandom;
            req_funct3[s] = 3'b010;
            req_valid[s]  = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(resp_valid[s]), 32'd1);
            check("hold_rdata", resp_rdata[s], e_rd);
            check("hold_err", 32'(resp_err[s]), 32'(e_err));
            check("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end
        req_valid[s]  = 1'b0;
        resp_ready[s] = 1'b1;
        @(negedge clk);
        resp_ready[s] = 1'b0;
        check("after_hs_valid", 32'(resp_valid[s]), 32'd0);
        check("after_hs_ready", 32'(req_ready[s]), 32'd1);
`ifdef DMEM_FAULT_LATCH_EN
        check("fault_valid", 32'(fault_valid[s]), 32'(fv[s]));
        check("fault_addr", fault_addr[s], fa[s]);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          s_r;
        bit          w_r;
        logic [31:0] a_r;
        logic [2:0]  f_r;

        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_write[s]  = 1'b0;
            req_addr[s]   = 32'd0;
            req_wdata[s]  = 32'd0;
            req_funct3[s] = 3'd0;
            resp_ready[s] = 1'b0;
            fv[s]         = 1'b0;
            fa[s]         = 32'd0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            check("rst_resp_rdata", resp_rdata[s], 32'd0);
            check("rst_resp_err", 32'(resp_err[s]), 32'd0);
        end
        rst = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                do_req(s, 1'b1, 32'(i * 4), $urandom, 3'b010, 0, rd, er);

        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er);
        check("sw10_rdata", rd, 32'd0);
        check("sw10_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        check("lw10", rd, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h13, 32'h00000080, 3'b000, 0, rd, er);
        do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        check("lw10_after_sb", rd, 32'h80ADBEEF);
        do_req(0, 1'b0, 32'h13, 32'd0, 3'b000, 0, rd, er);
        check("lb13", rd, 32'hFFFFFF80);
        do_req(0, 1'b0, 32'h13, 32'd0, 3'b100, 0, rd, er);
        check("lbu13", rd, 32'h00000080);
        do_req(0, 1'b1, 32'h22, 32'h00008001, 3'b001, 0, rd, er);
        do_req(0, 1'b0, 32'h22, 32'd0, 3'b001, 0, rd, er);
        check("lh22", rd, 32'hFFFF8001);
        do_req(0, 1'b0, 32'h22, 32'd0, 3'b101, 0, rd, er);
        check("lhu22", rd, 32'h00008001);
        do_req(0, 1'b0, 32'h20, 32'd0, 3'b101, 0, rd, er);

        do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, 5, rd, er);
        check("lw10_backpressure", rd, 32'h80ADBEEF);
        do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        check("lw10_not_overwritten", rd, 32'h80ADBEEF);

        do_req(0, 1'b0, 32'h11, 32'd0, 3'b010, 0, rd, er);
        check("lw11_err", 32'(er), 32'd1);
        check("lw11_rdata", rd, 32'd0);
        do_req(0, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, 0, rd, er);
        check("sw400_err", 32'(er), 32'd1);
        do_req(0, 1'b0, 32'h00, 32'd0, 3'b010, 0, rd, er);
        do_req(0, 1'b0, 32'h10, 32'd0, 3'b011, 0, rd, er);
        check("f3_011_err", 32'(er), 32'd1);
`ifdef DMEM_FAULT_LATCH_EN
        check("fault_addr_sticky", fault_addr[0], 32'h11);
`endif

        @(negedge clk);
        req_write[0]  = 1'b1;
        req_addr[0]   = 32'h30;
        req_wdata[0]  = 32'h12345678;
        req_funct3[0] = 3'b010;
        req_valid[0]  = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_req_ready", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        check("midrst_resp_rdata", resp_rdata[0], 32'd0);
        for (int s = 0; s < 2; s++) begin
            fv[s] = 1'b0;
            fa[s] = 32'd0;
        end
        do_req(0, 1'b0, 32'h30, 32'd0, 3'b010, 0, rd, er);

        do_req(1, 1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er);
        do_req(1, 1'b1, 32'h0B, 32'hFFFFFFA5, 3'b000, 2, rd, er);
        do_req(1, 1'b0, 32'h0B, 32'd0, 3'b000, 0, rd, er);

        repeat (160) begin
            s_r = int'($urandom_range(0, 1));
            w_r = 1'($urandom_range(0, 1));
            f_r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                a_r = 32'h400 + 32'($urandom_range(0, 255));
            else
                a_r = 32'($urandom_range(0, 63));
            do_req(s_r, w_r, a_r, $urandom, f_r, int'($urandom_range(0, 2)), rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
